// File: rtl/fibonacci_pkg.sv
// Shared definitions for the Fibonacci pattern generator: default width, term type
// and constant functions giving the largest representable term and its index.
package fibonacci_pkg;

    localparam int DEFAULT_WIDTH = 12;

    typedef logic [DEFAULT_WIDTH-1:0] term_t;

    // Largest Fibonacci term that fits in 'width' bits.
    function automatic longint unsigned fib_max(input int width);
        longint unsigned lim;
        longint unsigned a;
        longint unsigned b;
        longint unsigned t;
        lim = (longint'(1) << width) - 1;
        a   = 0;
        b   = 1;
        for (int i = 0; i < 64; i++) begin
            if (b <= lim) begin
                t = a + b;
                a = b;
                b = t;
            end
        end
        return a;
    endfunction

    // Index of fib_max(width) in the sequence F0, F1, F2, ...
    function automatic int fib_max_index(input int width);
        longint unsigned lim;
        longint unsigned a;
        longint unsigned b;
        longint unsigned t;
        int idx;
        lim = (longint'(1) << width) - 1;
        a   = 0;
        b   = 1;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (b <= lim) begin
                t   = a + b;
                a   = b;
                b   = t;
                idx = idx + 1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fibonacci_step.sv
// One Fibonacci step: WIDTH+1 bit sum of the current and next terms, with the
// carry-out exposed so the top can schedule a restart instead of truncating.
module fibonacci_step #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full;

    assign full  = {1'b0, cur} + {1'b0, nxt};
    assign sum   = full[WIDTH-1:0];
    assign carry = full[WIDTH];

endmodule

// File: rtl/fibonacci.sv
// Free-running Fibonacci generator, one term per clock, restarting at F0 after the
// largest term that fits. Define FIBONACCI_STATUS_EN to add the index/wrap outputs.
module fibonacci
    import fibonacci_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
`ifdef FIBONACCI_STATUS_EN
    ,
    output logic [5:0]       index,
    output logic             wrap
`endif
);

    logic [WIDTH-1:0] nxt_q;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             wrap_pend_q;

    fibonacci_step #(.WIDTH(WIDTH)) u_step (
        .cur   (out),
        .nxt   (nxt_q),
        .sum   (sum),
        .carry (carry)
    );

    // A carry while loading F_max means the term after it cannot be held, so the
    // following edge restarts from F0/F1 instead of using the truncated nxt_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            out         <= '0;
            nxt_q       <= WIDTH'(1);
            wrap_pend_q <= 1'b0;
        end else if (wrap_pend_q) begin
            out         <= '0;
            nxt_q       <= WIDTH'(1);
            wrap_pend_q <= 1'b0;
        end else begin
            out         <= nxt_q;
            nxt_q       <= sum;
            wrap_pend_q <= carry;
        end
    end

`ifdef FIBONACCI_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
            wrap  <= 1'b0;
        end else begin
            index <= wrap_pend_q ? 6'd0 : index + 6'd1;
            wrap  <= wrap_pend_q;
        end
    end
`endif

endmodule

// File: tb/tb_fibonacci.sv
// Directed bench for fibonacci: WIDTH=12 and WIDTH=8 instances share clock and reset;
// status outputs are checked when FIBONACCI_STATUS_EN is defined.
module tb_fibonacci;
    import fibonacci_pkg::*;

    logic        clk;
    logic        rst;
    term_t       out12;
    logic [7:0]  out8;
`ifdef FIBONACCI_STATUS_EN
    logic [5:0]  index12;
    logic        wrap12;
    logic [5:0]  index8;
    logic        wrap8;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Edges 0..21 after one reset edge (edge 0 is the reset edge itself).
    int exp12 [22] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610,
                       987, 1597, 2584, 0, 1, 1};
    int exp8  [22] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 0, 1,
                       1, 2, 3, 5, 8, 13};

    fibonacci #(.WIDTH(12)) u_dut12 (
        .clk   (clk),
        .rst   (rst),
        .out   (out12)
`ifdef FIBONACCI_STATUS_EN
        ,
        .index (index12),
        .wrap  (wrap12)
`endif
    );

    fibonacci #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .out   (out8)
`ifdef FIBONACCI_STATUS_EN
        ,
        .index (index8),
        .wrap  (wrap8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step();

        // Reset edge, then 21 free-running edges through the wrap of both widths.
        for (int e = 0; e < 22; e++) begin
            if (e > 0) step();
            check($sformatf("seq12[%0d]", e), 32'(out12), 32'(exp12[e]));
            check($sformatf("seq8[%0d]", e), 32'(out8), 32'(exp8[e]));
`ifdef FIBONACCI_STATUS_EN
            check($sformatf("idx12[%0d]", e), 32'(index12), 32'(e % 19));
            check($sformatf("wrap12[%0d]", e), 32'(wrap12), (e == 19) ? 32'd1 : 32'd0);
            check($sformatf("idx8[%0d]", e), 32'(index8), 32'(e % 14));
            check($sformatf("wrap8[%0d]", e), 32'(wrap8), (e == 14) ? 32'd1 : 32'd0);
`endif
            rst = 1'b0;
        end

        // Mid-run reset after out reaches 55.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 0; e < 10; e++) step();
        check("pre_mid_rst", 32'(out12), 32'd55);
        rst = 1'b1;
        step();
        check("mid_rst", 32'(out12), 32'd0);
`ifdef FIBONACCI_STATUS_EN
        check("mid_rst_idx", 32'(index12), 32'd0);
        check("mid_rst_wrap", 32'(wrap12), 32'd0);
`endif
        rst = 1'b0;
        step();
        check("mid_rel0", 32'(out12), 32'd1);
        step();
        check("mid_rel1", 32'(out12), 32'd1);
        step();
        check("mid_rel2", 32'(out12), 32'd2);

        // Reset held five edges.
        rst = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step();
            check($sformatf("held12[%0d]", e), 32'(out12), 32'd0);
            check($sformatf("held8[%0d]", e), 32'(out8), 32'd0);
`ifdef FIBONACCI_STATUS_EN
            check($sformatf("held_wrap[%0d]", e), 32'(wrap12), 32'd0);
`endif
        end
        rst = 1'b0;
        step();
        check("held_rel12", 32'(out12), 32'd1);
        check("held_rel8", 32'(out8), 32'd1);

        // Reset landing while F_max is on out must cancel the pending wrap.
        for (int e = 1; e < 18; e++) step();
        check("peak12", 32'(out12), 32'd2584);
        rst = 1'b1;
        step();
        check("peak_rst", 32'(out12), 32'd0);
`ifdef FIBONACCI_STATUS_EN
        check("peak_rst_wrap", 32'(wrap12), 32'd0);
`endif
        rst = 1'b0;
        step();
        check("peak_rel0", 32'(out12), 32'd1);
`ifdef FIBONACCI_STATUS_EN
        check("peak_rel_wrap", 32'(wrap12), 32'd0);
        check("peak_rel_idx", 32'(index12), 32'd1);
`endif
        step();
        check("peak_rel1", 32'(out12), 32'd1);

        // Period measured against the package's own F_max index.
        for (int e = 2; e < fib_max_index(12) + 1; e++) step();
        check("period12", 32'(out12), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
